// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: shares the core memory port between IF line fetches and MEM-stage fills/writebacks.
// Optional IF anti-starvation streak counter is enabled by defining SEGRE_ARB_FAIRNESS_EN.
package segre_mem_arbiter_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memop_data_type_e;
endpackage

module segre_mem_arbiter
  import segre_mem_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE             = 32,
  parameter int CACHE_LINE_SIZE_BYTES = 16,
  parameter int MAX_MEM_STREAK        = 4
) (
  input  logic                               clk_i,
  input  logic                               rsn_i,
  input  logic                               if_req_i,
  input  logic [ADDR_SIZE-1:0]               if_addr_i,
  output logic                               if_ready_o,
  input  logic                               ms_rd_i,
  input  logic                               ms_wr_i,
  input  logic [ADDR_SIZE-1:0]               ms_addr_i,
  input  memop_data_type_e                   ms_data_type_i,
  input  logic [CACHE_LINE_SIZE_BYTES*8-1:0] ms_wr_data_i,
  output logic                               ms_ready_o,
  output logic [ADDR_SIZE-1:0]               addr_o,
  output logic                               mem_rd_o,
  output logic                               mem_wr_o,
  output memop_data_type_e                   mem_data_type_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0] mem_wr_data_o,
  input  logic                               mem_ready_i,
  output logic                               sel_mem_req_o,
  output logic                               busy_o
);
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MS} state_e;
  state_e                             r_state;
  logic [ADDR_SIZE-1:0]               r_addr;
  logic                               r_rd, r_wr;
  memop_data_type_e                   r_type;
  logic [CACHE_LINE_SIZE_BYTES*8-1:0] r_wr_data;
  logic                               w_ms_req, w_sample, w_fair_turn, w_if_wins;
`ifdef SEGRE_ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  logic [SW-1:0] r_streak;
  assign w_fair_turn = (r_streak == SW'(MAX_MEM_STREAK));
`else
  assign w_fair_turn = 1'b0;
`endif
  assign w_ms_req  = ms_rd_i | ms_wr_i;
  // Arbitrate only when the port is free or is being freed this cycle.
  assign w_sample  = (r_state == IDLE) | mem_ready_i;
  assign w_if_wins = if_req_i & (~w_ms_req | w_fair_turn);
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_type    <= WORD;
      r_wr_data <= '0;
`ifdef SEGRE_ARB_FAIRNESS_EN
      r_streak  <= '0;
`endif
    end else begin
      if (w_sample) begin
        r_state <= w_if_wins ? GNT_IF : w_ms_req ? GNT_MS : IDLE;
        if (w_if_wins) begin
          r_addr <= if_addr_i;
          r_rd   <= 1'b1;
          r_wr   <= 1'b0;
          r_type <= WORD;
        end else if (w_ms_req) begin
          r_addr    <= ms_addr_i;
          r_rd      <= ~ms_wr_i;
          r_wr      <= ms_wr_i;
          r_type    <= ms_data_type_i;
          r_wr_data <= ms_wr_data_i;
        end else begin
          r_rd <= 1'b0;
          r_wr <= 1'b0;
        end
      end
`ifdef SEGRE_ARB_FAIRNESS_EN
      if (!if_req_i || (w_sample && w_if_wins)) r_streak <= '0;
      else if (w_sample && w_ms_req && !w_fair_turn) r_streak <= r_streak + 1'b1;
`endif
    end
  end
  assign if_ready_o      = mem_ready_i & (r_state == GNT_IF);
  assign ms_ready_o      = mem_ready_i & (r_state == GNT_MS);
  assign addr_o          = r_addr;
  assign mem_rd_o        = r_rd;
  assign mem_wr_o        = r_wr;
  assign mem_data_type_o = r_type;
  assign mem_wr_data_o   = r_wr_data;
  assign sel_mem_req_o   = (r_state == GNT_MS);
  assign busy_o          = (r_state != IDLE);
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: randomized requesters and memory checked against a transaction-level owner model.
module tb_segre_mem_arbiter;
  import segre_mem_arbiter_pkg::*;
  localparam int AW = 32, LW = 128, MAXS = 4;
  logic             clk_i = 1'b0, rsn_i;
  logic             if_req_i, ms_rd_i, ms_wr_i, mem_ready_i;
  logic [AW-1:0]    if_addr_i, ms_addr_i;
  memop_data_type_e ms_data_type_i;
  logic [LW-1:0]    ms_wr_data_i;
  logic             if_ready_o, ms_ready_o, mem_rd_o, mem_wr_o, sel_mem_req_o, busy_o;
  logic [AW-1:0]    addr_o;
  memop_data_type_e mem_data_type_o;
  logic [LW-1:0]    mem_wr_data_o;

  always #5 clk_i = ~clk_i;

  segre_mem_arbiter #(.ADDR_SIZE(AW), .CACHE_LINE_SIZE_BYTES(16), .MAX_MEM_STREAK(MAXS)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .ms_rd_i(ms_rd_i), .ms_wr_i(ms_wr_i), .ms_addr_i(ms_addr_i),
    .ms_data_type_i(ms_data_type_i), .ms_wr_data_i(ms_wr_data_i), .ms_ready_o(ms_ready_o),
    .addr_o(addr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_data_type_o(mem_data_type_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_ready_i(mem_ready_i), .sel_mem_req_o(sel_mem_req_o), .busy_o(busy_o)
  );

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: who owns the port (0 none, 1 IF, 2 MEM) and the transaction it presented.
  int               m_own = 0, m_streak = 0, n_own;
  logic [AW-1:0]    m_addr = '0;
  logic             m_rd = 1'b0, m_wr = 1'b0;
  memop_data_type_e m_type = WORD;
  logic [LW-1:0]    m_data = '0;
  logic             e_if, e_ms;
  int               if_grants = 0, ms_grants = 0;

  function automatic int winner();
    bit ms = ms_rd_i || ms_wr_i;
    bit fair;
`ifdef SEGRE_ARB_FAIRNESS_EN
    fair = (m_streak == MAXS);
`else
    fair = 1'b0;
`endif
    if (if_req_i && (!ms || fair)) return 1;
    if (ms) return 2;
    return 0;
  endfunction

  task automatic check_all(input string p);
    check({p, "if_ready"}, LW'(if_ready_o), LW'(e_if));
    check({p, "ms_ready"}, LW'(ms_ready_o), LW'(e_ms));
    check({p, "addr"}, LW'(addr_o), LW'(m_addr));
    check({p, "rd"}, LW'(mem_rd_o), LW'(m_rd));
    check({p, "wr"}, LW'(mem_wr_o), LW'(m_wr));
    check({p, "type"}, LW'(mem_data_type_o), LW'(m_type));
    check({p, "wdata"}, mem_wr_data_o, m_data);
    check({p, "sel"}, LW'(sel_mem_req_o), LW'(m_own == 2));
    check({p, "busy"}, LW'(busy_o), LW'(m_own != 0));
  endtask

  task automatic new_ms();
    int k = $urandom_range(0, 2);
    ms_rd_i        = (k != 1);
    ms_wr_i        = (k != 0);
    ms_addr_i      = $urandom;
    ms_data_type_i = memop_data_type_e'($urandom_range(0, 2));
    ms_wr_data_i   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rsn_i = 1'b0; if_req_i = 0; ms_rd_i = 0; ms_wr_i = 0; mem_ready_i = 1;
    if_addr_i = '0; ms_addr_i = '0; ms_data_type_i = BYTE; ms_wr_data_i = '0;
    #12;
    e_if = 0; e_ms = 0;
    check_all("rst_");
    @(posedge clk_i); #1;
    rsn_i = 1'b1; mem_ready_i = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      e_if = mem_ready_i && m_own == 1;
      e_ms = mem_ready_i && m_own == 2;
      check_all("");
      n_own = (m_own == 0 || mem_ready_i) ? winner() : m_own;
      @(posedge clk_i); #1;
`ifdef SEGRE_ARB_FAIRNESS_EN
      if (!if_req_i || (n_own == 1 && n_own != m_own) || (n_own == 1 && (m_own == 0 || e_if || e_ms))) m_streak = 0;
      else if ((m_own == 0 || e_if || e_ms) && n_own == 2 && m_streak < MAXS) m_streak++;
`endif
      if (m_own == 0 || e_if || e_ms) begin
        if (n_own == 1) begin
          m_addr = if_addr_i; m_rd = 1; m_wr = 0; m_type = WORD; if_grants++;
        end else if (n_own == 2) begin
          m_addr = ms_addr_i; m_rd = !ms_wr_i; m_wr = ms_wr_i; m_type = ms_data_type_i;
          m_data = ms_wr_data_i; ms_grants++;
        end else begin
          m_rd = 0; m_wr = 0;
        end
        m_own = n_own;
      end
      if (!if_req_i || e_if) begin
        if_req_i  = ($urandom_range(0, 3) != 0);
        if_addr_i = $urandom;
      end
      if (!(ms_rd_i || ms_wr_i) || e_ms) begin
        if ($urandom_range(0, 7) != 0) new_ms();
        else begin ms_rd_i = 0; ms_wr_i = 0; end
      end
      mem_ready_i = ($urandom_range(0, 2) == 0);
    end
    check("if_granted", LW'(if_grants > 0), LW'(1));
    check("ms_granted", LW'(ms_grants > 0), LW'(1));
    if_req_i = 0; ms_rd_i = 0; ms_wr_i = 0; mem_ready_i = 1;
    @(posedge clk_i); #1;
    ms_rd_i = 1; ms_wr_i = 1; ms_addr_i = 32'h2000; mem_ready_i = 0;
    @(posedge clk_i); #1;
    check("both_wr", LW'(mem_wr_o), LW'(1));
    check("both_rd", LW'(mem_rd_o), LW'(0));
    check("both_addr", LW'(addr_o), LW'(32'h2000));
    check("both_sel", LW'(sel_mem_req_o), LW'(1));
    #2 rsn_i = 1'b0;
    #1;
    m_own = 0; m_addr = '0; m_rd = 0; m_wr = 0; m_type = WORD; m_data = '0;
    e_if = 0; e_ms = 0;
    check_all("midrst_");
    mem_ready_i = 1;
    #1 check_all("midrst_rdy_");
    @(posedge clk_i); #1;
    check_all("inrst_");
    ms_rd_i = 0; ms_wr_i = 0; rsn_i = 1'b1;
    #1 check_all("idle_rdy_");
    @(posedge clk_i); #1;
    check_all("idle_rdy2_");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
